// File: rtl/round_robin_select.sv
// ---------------------------------------------------------------------------
// round_robin_select
//
// Arbitrates four requesters onto a 4-input multiplexer. It drives the
// multiplexer address, a one-hot grant and a valid flag, and counts the
// completed handshakes with the downstream consumer.
//
// Handshake: a transfer completes on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, addresses, grant and
// out_valid stay frozen whatever req does. On a completed transfer a new
// winner is loaded in the same edge if any request is pending, so there is
// no bubble between back-to-back transfers.
//
// Configuration macro: RR_SELECT_ROTATE_EN
//   defined     -> rotating priority; after each transfer the search
//                  starts one past the address just served.
//   not defined -> fixed priority, source 0 highest, source 3 lowest.
//
// Ports
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   req         in   4  request per source
//   out_ready   in   1  downstream accepts this cycle
//   addresses   out  2  registered multiplexer select
//   grant       out  4  registered one-hot grant (0 when idle)
//   out_valid   out  1  registered, multiplexer output valid
//   xfer_count  out  8  registered count of completed handshakes (wraps)
//   dbg_state   out  1  FSM state (0 = IDLE, 1 = GRANT)
// ---------------------------------------------------------------------------
module round_robin_select (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       out_ready,
   output logic [1:0] addresses,
   output logic [3:0] grant,
   output logic       out_valid,
   output logic [7:0] xfer_count,
   output logic       dbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_addr;
   logic [1:0] w_addr_nxt;
   logic [3:0] r_grant;
   logic [3:0] w_grant_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;

   logic       w_xfer;
   logic       w_any_req;
   logic [1:0] w_base;
   logic [3:0] w_req_rot;
   logic [1:0] w_offset;
   logic [1:0] w_winner;

   assign w_xfer    = (r_state == S_GRANT) && out_ready;
   assign w_any_req = |req;

`ifdef RR_SELECT_ROTATE_EN
   logic [1:0] r_ptr;
   logic [1:0] w_addr_inc;

   assign w_addr_inc = r_addr + 2'd1;

   // On a transfer edge the pointer is being updated in that same edge, so
   // the back-to-back winner must be searched from the updated value.
   assign w_base = w_xfer ? w_addr_inc : r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 2'd0;
      end else if (w_xfer) begin
         r_ptr <= w_addr_inc;
      end
   end
`else
   assign w_base = 2'd0;
`endif

   // Rotate req so that bit 0 is the source at the search base, pick the
   // lowest set bit, then undo the rotation by adding the base back.
   always_comb begin
      w_req_rot = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         w_req_rot[k] = req[2'(w_base + 2'(k))];
      end
   end

   always_comb begin
      w_offset = 2'd0;
      if (w_req_rot[3]) w_offset = 2'd3;
      if (w_req_rot[2]) w_offset = 2'd2;
      if (w_req_rot[1]) w_offset = 2'd1;
      if (w_req_rot[0]) w_offset = 2'd0;
   end

   assign w_winner = w_base + w_offset;

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_grant_nxt = r_grant;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = S_GRANT;
               w_addr_nxt  = w_winner;
               w_grant_nxt = 4'b0001 << w_winner;
            end
         end
         S_GRANT: begin
            if (out_ready) begin
               w_cnt_nxt = r_cnt + 8'd1;
               if (w_any_req) begin
                  w_addr_nxt  = w_winner;
                  w_grant_nxt = 4'b0001 << w_winner;
               end else begin
                  // addresses keeps its last value on the way back to idle
                  w_state_nxt = S_IDLE;
                  w_grant_nxt = 4'b0000;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= 2'd0;
         r_grant <= 4'b0000;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_grant <= w_grant_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign addresses  = r_addr;
   assign grant      = r_grant;
   assign out_valid  = (r_state == S_GRANT);
   assign xfer_count = r_cnt;
   assign dbg_state  = (r_state == S_GRANT);

endmodule

// File: doc/round_robin_select.md
ROUND_ROBIN_SELECT -- requirements
Module: round_robin_select

Interface
REQ-001 Parameters: none; all widths fixed (4 sources, 2-bit select).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  request per source; bit i = source i wants the 4-input multiplexer.
REQ-005 out_ready  input  1  downstream consumer of the multiplexer output accepts this cycle.
REQ-006 addresses  output  2  registered select driving the 4-input multiplexer address port.
REQ-007 grant  output  4  registered one-hot grant; grant[addresses]=1 when out_valid, else 4'b0000.
REQ-008 out_valid  output  1  registered; multiplexer output is valid for the granted source.
REQ-009 xfer_count  output  8  registered count of completed handshakes.

Function
REQ-010 States: IDLE (out_valid=0), GRANT (out_valid=1); one state register, no other states.
REQ-011 Handshake: transfer completes on a rising edge where out_valid=1 and out_ready=1.
REQ-012 IDLE, req=0: remain IDLE; outputs hold, grant=0.
REQ-013 IDLE, req!=0: at next edge go GRANT, load addresses with the winner, set grant one-hot; latency one cycle from req sampled to out_valid.
REQ-014 Winner: first set bit of req searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), ptr a 2-bit priority pointer.
REQ-015 GRANT, out_ready=0: addresses, grant, out_valid held stable, regardless of req changes (including the granted bit dropping).
REQ-016 GRANT, out_ready=1: ptr <= addresses+1 (wraps 3->0); xfer_count increments.
REQ-017 Same edge as REQ-016, req!=0: stay GRANT, load new winner using the updated ptr (back-to-back, no bubble).
REQ-018 Same edge as REQ-016, req=0: go IDLE, grant<=0, out_valid<=0; addresses holds last value.
REQ-019 Winner selection in REQ-017 considers the full current req vector, including the just-served source.
REQ-020 xfer_count wraps 255->0; no saturation, no overflow flag.
REQ-021 out_ready ignored in IDLE; no count change.

Reset
REQ-022 rst_n=0 asynchronously forces: state IDLE, ptr=0, addresses=2'b00, grant=4'b0000, out_valid=0, xfer_count=0.
REQ-023 Reset mid-GRANT abandons the pending grant; no handshake counted.
REQ-024 First evaluation after rst_n deassertion occurs at the first rising edge with rst_n=1.

Configuration
REQ-025 Macro RR_SELECT_ROTATE_EN: defined -> rotating priority per REQ-014/REQ-016.
REQ-026 Not defined -> fixed priority, source 0 highest, source 3 lowest; ptr constant 0; all other behaviour identical.

Verification
REQ-027 Reset: rst_n=0 mid-GRANT with addresses=2 -> immediately out_valid=0, grant=0000, addresses=00, xfer_count=0.
REQ-028 req=1010, out_ready=1, ptr=0 (rotate on) -> grants cycle 1,3,1,3 on consecutive edges, out_valid stays 1, xfer_count +1 per cycle.
REQ-029 req=0100 one cycle then 0000, out_ready=0 for 5 cycles -> addresses=10, grant=0100 held 5 cycles; on out_ready=1, next edge IDLE, xfer_count=1.
REQ-030 req=1111, out_ready=1 continuous for 8 cycles (rotate on) -> addresses 0,1,2,3,0,1,2,3; (rotate off) -> addresses 0 every cycle.
REQ-031 Preload xfer_count=255 via 255 handshakes, one more handshake -> xfer_count=0.
REQ-032 With each granted address, 4-input multiplexer fed inputs=4'b1001 -> observed mux output equals inputs[addresses] while out_valid=1.
